// File: rtl/nf_mem_arbiter.sv
// nf_mem_arbiter: shares one memory/peripheral port between the CPU data port
// (master 0) and the instruction port (master 1). Master 0 has fixed priority,
// master 1 is guaranteed a grant after MAX_CONSEC back-to-back master-0 grants,
// and a stuck slave is error-completed after TIMEOUT cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrates requests seen this cycle
// GNT0  | master 0 owns the slave port until ack_s or timeout
// GNT1  | master 1 owns the slave port until ack_s or timeout
module nf_mem_arbiter #(
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic [31:0] addr_m0,
    input  logic [31:0] wd_m0,
    input  logic        we_m0,
    input  logic        req_m0,
    output logic        ack_m0,
    output logic [31:0] rd_m0,
    output logic        err_m0,

    input  logic [31:0] addr_m1,
    input  logic [31:0] wd_m1,
    input  logic        we_m1,
    input  logic        req_m1,
    output logic        ack_m1,
    output logic [31:0] rd_m1,
    output logic        err_m1,

    output logic [31:0] addr_s,
    output logic [31:0] wd_s,
    output logic        we_s,
    output logic        req_s,
    input  logic        ack_s,
    input  logic [31:0] rd_s,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(MAX_CONSEC);
    localparam logic       TO_EN      = (TIMEOUT != 0);
    // Last grant cycle index before the timeout fires (unused when disabled).
    localparam logic [7:0] TO_LAST    = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] starve_nxt;
    logic [7:0] to_cnt;
    logic [7:0] to_nxt;
    logic       to_fire;

    // A real ack in the same cycle always wins over the timeout.
    assign to_fire = TO_EN && (state != IDLE) && !ack_s && (to_cnt == TO_LAST);

    // State and counter registers; reset drops the grant immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            to_cnt     <= 8'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            to_cnt     <= to_nxt;
        end
    end

    // Arbitration, slave-port mux and completion routing.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        to_nxt     = to_cnt;
        req_s      = 1'b0;
        addr_s     = 32'd0;
        wd_s       = 32'd0;
        we_s       = 1'b0;
        grant      = 2'b00;
        ack_m0     = 1'b0;
        rd_m0      = 32'd0;
        err_m0     = 1'b0;
        ack_m1     = 1'b0;
        rd_m1      = 32'd0;
        err_m1     = 1'b0;

        case (state)
            IDLE: begin
                to_nxt = 8'd0;
                if (req_m0 && req_m1 && (starve_cnt == STARVE_MAX)) begin
                    state_nxt  = GNT1;
                    starve_nxt = 4'd0;
                end else if (req_m0) begin
                    state_nxt = GNT0;
                    if (!req_m1) begin
                        starve_nxt = 4'd0;
                    end else if (starve_cnt != STARVE_MAX) begin
                        starve_nxt = starve_cnt + 4'd1;
                    end
                end else if (req_m1) begin
                    state_nxt  = GNT1;
                    starve_nxt = 4'd0;
                end else begin
                    starve_nxt = 4'd0;
                end
            end

            GNT0: begin
                req_s  = 1'b1;
                addr_s = addr_m0;
                wd_s   = wd_m0;
                we_s   = we_m0;
                grant  = 2'b01;
                if (ack_s || to_fire) begin
                    ack_m0    = 1'b1;
                    err_m0    = to_fire;
                    if (ack_s) rd_m0 = rd_s;
                    state_nxt = IDLE;
                    to_nxt    = 8'd0;
                end else begin
                    to_nxt = to_cnt + 8'd1;
                end
            end

            GNT1: begin
                req_s  = 1'b1;
                addr_s = addr_m1;
                wd_s   = wd_m1;
                we_s   = we_m1;
                grant  = 2'b10;
                if (ack_s || to_fire) begin
                    ack_m1    = 1'b1;
                    err_m1    = to_fire;
                    if (ack_s) rd_m1 = rd_s;
                    state_nxt = IDLE;
                    to_nxt    = 8'd0;
                end else begin
                    to_nxt = to_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/nf_mem_arbiter.md
Name: nf_mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares a single memory port between the CPU data port (master 0) and the instruction port (master 1).
- Sits between the cpu core and the unified RAM/peripheral bus.
- Uses the existing req/req_ack handshake.
- Fixed priority to master 0, with an anti-starvation limit for master 1 and a per-transaction slave timeout.

Parameters:
MAX_CONSEC, 4, max consecutive master-0 grants while master 1 is waiting (1..15)
TIMEOUT, 64, cycles to wait for ack_s before error-completing; 0 disables the timeout (1..255 otherwise)

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  reset, asynchronous, active-low
addr_m0  input  32  master 0 address
wd_m0  input  32  master 0 write data
we_m0  input  1  master 0 write enable
req_m0  input  1  master 0 request, held until ack_m0
ack_m0  output  1  master 0 completion pulse
rd_m0  output  32  master 0 read data, valid while ack_m0=1
err_m0  output  1  master 0 timeout error, only with ack_m0
addr_m1  input  32  master 1 address
wd_m1  input  32  master 1 write data
we_m1  input  1  master 1 write enable
req_m1  input  1  master 1 request, held until ack_m1
ack_m1  output  1  master 1 completion pulse
rd_m1  output  32  master 1 read data, valid while ack_m1=1
err_m1  output  1  master 1 timeout error, only with ack_m1
addr_s  output  32  slave address
wd_s  output  32  slave write data
we_s  output  1  slave write enable
req_s  output  1  slave request
ack_s  input  1  slave acknowledge
rd_s  input  32  slave read data, valid with ack_s
grant  output  2  current owner: 00 none, 01 master 0, 10 master 1

Behaviour:
- Clock/reset: one clock, clk; resetn asynchronous, active-low.
- Reset state: FSM IDLE, starve_cnt=0, to_cnt=0.
- Reset output values: all outputs 0.
- Master protocol: the master raises req with addr/wd/we stable and holds them until its ack. It may drop req only in the cycle after ack, and may re-raise it one or more cycles later.
- FSM states: IDLE, GNT0, GNT1.
- IDLE, both requesting: if req_m0 && req_m1 && starve_cnt==MAX_CONSEC, go to GNT1. Otherwise go to GNT0.
- IDLE, single requester: if only req_m0, go to GNT0; if only req_m1, go to GNT1; if neither, stay in IDLE.
- starve_cnt: increments on each IDLE->GNT0 transition taken while req_m1=1. It clears on IDLE->GNT1, and clears in IDLE when req_m1=0. It saturates at MAX_CONSEC.
- GNT0/GNT1 outputs: req_s=1; addr_s/wd_s/we_s combinationally muxed from the granted master; grant reflects the state. In IDLE, req_s=0, we_s=0, and addr_s/wd_s=0.
- Completion: ack_s=1 in a GNT state gives ack_mX=1 and rd_mX=rd_s for that cycle (combinational passthrough); the next state is IDLE. Non-granted ack/rd/err stay 0.
- Re-arbitration: one mandatory IDLE cycle between transactions. Minimum spacing is 2 cycles per transfer; req-to-req_s latency is 1 cycle.
- Timeout counting: to_cnt clears on entry to GNT and increments each GNT cycle without ack_s.
- Timeout firing: if TIMEOUT!=0 and to_cnt==TIMEOUT-1 with ack_s=0, assert ack_mX=1, err_mX=1, rd_mX=0 for one cycle, then go to IDLE.
- ack_s together with timeout: if ack_s=1 in the same cycle, it is a normal completion with err=0.
- ack_s in IDLE: ignored, no ack to any master. This covers late slave acks after a timeout.
- Request withdrawal: a master dropping req while granted is a protocol violation. The arbiter keeps the grant until ack_s or timeout.
- Reset mid-transaction: everything returns to IDLE immediately and req_s drops asynchronously. No ack is generated.

Test Plan:
- Single master 0: read of addr 0x100; slave acks 2 cycles after req_s with rd_s=0x12345678 -> req_s rises 1 cycle after req_m0, addr_s=0x100, ack_m0 1-cycle pulse with rd_m0=0x12345678, grant=01 then 00.
- Simultaneous requests: req_m0 and req_m1 together, slave 1-cycle ack -> master 0 served first, then IDLE cycle, then master 1; ack_m1 never overlaps ack_m0.
- Starvation: master 0 re-requests continuously, master 1 held high, MAX_CONSEC=4 -> exactly 4 master-0 grants, then one master-1 grant, after which starve_cnt=0.
- Timeout: TIMEOUT=8, slave never acks a master-1 write -> after 8 GNT1 cycles, ack_m1=1, err_m1=1, rd_m1=0; req_s drops; a late ack_s in IDLE produces no ack.
- Timeout disabled: TIMEOUT=0, slave acks after 300 cycles -> normal ack, err=0.
- Reset mid-transaction: resetn low during GNT0 -> req_s, grant, ack_m0 go 0 asynchronously; after release, a fresh req_m1 is granted normally.
